mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the two cores' instruction caches and the coherence bus data port (dREN/dWEN/daddr/dstore/dload/dwait).
- Sits between the coherence controller and RAM. Grants one requester at a time and holds the grant until RAM reports ACCESS.
- Data port has priority; the icaches rotate round-robin.
- A streak counter prevents data-side starvation of instruction fetch.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while any iREN is pending before one icache grant is forced (1..15)
BAD, 32'hBAD1BAD1, value driven on non-granted load outputs

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  2  icache read request, bit n = core n
iaddr  input  2x32  icache address per core
iwait  output  2  icache wait per core; 0 = data valid this cycle
iload  output  2x32  icache read data per core
dREN  input  1  coherence bus read
dWEN  input  1  coherence bus write
daddr  input  32  coherence bus address
dstore  input  32  coherence bus write data
dwait  output  1  coherence bus wait; 0 = transfer complete this cycle
dload  output  32  coherence bus read data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramstate  input  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
ramload  input  32  RAM read data

Behaviour:
- Clock CLK. Reset nRST, asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, dstreak=0
  - iwait=2'b11, dwait=1
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
  - iload={BAD,BAD}, dload=BAD
- States: IDLE, DSERVE, ISERVE. A registered grant index (gidx, 1 bit) selects the icache in ISERVE.
- IDLE: RAM enables are 0 and all waits are 1. Next state, evaluated in this order:
  - (dREN|dWEN) and (iREN==0 or dstreak<MAX_DSTREAK) -> DSERVE, dstreak += 1, saturating at 15.
  - Otherwise, any iREN -> ISERVE. gidx = rr_ptr if iREN[rr_ptr] is set, else the other bit. dstreak <= 0.
  - Otherwise, stay in IDLE. If iREN==0, dstreak <= 0.
- Arbitration latency: exactly one cycle in IDLE between a request rising and its RAM enable asserting.
- DSERVE:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are high).
  - dload=ramload.
  - dwait = ~(ramstate==ACCESS).
  - On ACCESS -> IDLE.
- ISERVE:
  - ramaddr=iaddr[gidx], ramREN=1, ramWEN=0.
  - iload[gidx]=ramload, iwait[gidx] = ~(ramstate==ACCESS).
  - On ACCESS -> IDLE and rr_ptr <= ~gidx.
- Non-granted requesters always see wait=1 and load=BAD.
- Requester withdrawal: if the granted request drops before ACCESS (dREN|dWEN or iREN[gidx] goes to 0):
  - RAM enables go to 0 combinationally.
  - Next state is IDLE; rr_ptr and dstreak are unchanged.
- ramstate ERROR or BUSY: treated as not complete. Wait stays 1 and the grant is held; there is no timeout.
- dstreak only counts while an icache is pending. With MAX_DSTREAK=4 and continuous data traffic, at most 4 data transfers complete before one icache fetch is served.
- Back-to-back: after the ACCESS cycle the block always spends one IDLE cycle, so the minimum per-transfer occupancy is 2 cycles.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronous) and any in-flight RAM operation is abandoned.

Test Plan:
- Reset, then dREN=1, daddr=0x100, RAM returns ACCESS two cycles after ramREN rises with ramload=0x12345678 -> ramREN asserts cycle 1 after request; dwait=0 and dload=0x12345678 for exactly one cycle; state returns to IDLE.
- iREN=2'b11 held, single-cycle ACCESS RAM -> grants alternate core0, core1, core0; each iwait[n]=0 for one cycle per grant; the other core's iload=0xBAD1BAD1.
- dWEN=1 continuously (dstore=0xCAFEF00D), iREN[1]=1, MAX_DSTREAK=4 -> four ramWEN transfers complete, then one ISERVE for core1, then data resumes.
- dREN=1 and dWEN=1 simultaneously -> ramWEN=1, ramREN=0, ramstore=dstore.
- ISERVE for core0, RAM BUSY then iREN[0] drops -> ramREN=0 the same cycle, IDLE next, rr_ptr unchanged (next grant goes to core0 again).
- nRST pulsed low during DSERVE with ramstate=BUSY -> ramWEN/ramREN=0 and dwait=1 immediately; after release, state=IDLE, rr_ptr=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one RAM port between two icaches and the coherence bus
//               data port. Data has priority, icaches rotate round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int          MAX_DSTREAK = 4,
    parameter logic [31:0] BAD         = 32'hBAD1BAD1
) (
    input  logic             CLK,
    input  logic             nRST,
    // instruction caches
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    // coherence bus data port
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    // RAM
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [1:0]       ramstate,
    input  logic [31:0]      ramload
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } state_t;

    localparam logic [1:0] c_RAM_ACCESS   = 2'b10;
    localparam logic [3:0] c_DSTREAK_SAT  = 4'hF;
    localparam logic [3:0] c_MAX_DSTREAK  = 4'(MAX_DSTREAK);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_rr_ptr;
    logic       w_next_rr_ptr;
    logic       r_gidx;
    logic       w_next_gidx;
    logic [3:0] r_dstreak;
    logic [3:0] w_next_dstreak;

    logic       w_dreq;
    logic       w_ireq_any;
    logic       w_access;
    logic       w_igrant_live;

    assign w_dreq        = dREN | dWEN;
    assign w_ireq_any    = |iREN;
    assign w_access      = (ramstate == c_RAM_ACCESS);
    assign w_igrant_live = iREN[r_gidx];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_rr_ptr  <= 1'b0;
            r_gidx    <= 1'b0;
            r_dstreak <= 4'd0;
        end else begin
            r_state   <= w_next_state;
            r_rr_ptr  <= w_next_rr_ptr;
            r_gidx    <= w_next_gidx;
            r_dstreak <= w_next_dstreak;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_rr_ptr  = r_rr_ptr;
        w_next_gidx    = r_gidx;
        w_next_dstreak = r_dstreak;

        iwait    = 2'b11;
        iload    = {BAD, BAD};
        dwait    = 1'b1;
        dload    = BAD;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;

        case (r_state)
            IDLE: begin
                if (w_dreq && (!w_ireq_any || (r_dstreak < c_MAX_DSTREAK))) begin
                    w_next_state = DSERVE;
                    // The streak only measures how long a pending fetch has been held off.
                    if (w_ireq_any) begin
                        w_next_dstreak = (r_dstreak == c_DSTREAK_SAT) ? r_dstreak
                                                                      : r_dstreak + 4'd1;
                    end else begin
                        w_next_dstreak = 4'd0;
                    end
                end else if (w_ireq_any) begin
                    w_next_state   = ISERVE;
                    w_next_gidx    = iREN[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
                    w_next_dstreak = 4'd0;
                end else begin
                    w_next_dstreak = 4'd0;
                end
            end

            DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (w_dreq) begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    dwait  = ~w_access;
                    if (w_access) begin
                        w_next_state = IDLE;
                    end
                end else begin
                    // Requester withdrew: abandon without touching arbitration history.
                    w_next_state = IDLE;
                end
            end

            ISERVE: begin
                ramaddr        = iaddr[r_gidx];
                iload[r_gidx]  = ramload;
                if (w_igrant_live) begin
                    ramREN        = 1'b1;
                    iwait[r_gidx] = ~w_access;
                    if (w_access) begin
                        w_next_state  = IDLE;
                        w_next_rr_ptr = ~r_gidx;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [31:0] c_BAD    = 32'hBAD1BAD1;
    localparam logic [1:0]  c_FREE   = 2'b00;
    localparam logic [1:0]  c_BUSY   = 2'b01;
    localparam logic [1:0]  c_ACCESS = 2'b10;
    localparam logic [31:0] c_IADDR0 = 32'h0000_1000;
    localparam logic [31:0] c_IADDR1 = 32'h0000_2000;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic             dREN;
    logic             dWEN;
    logic [31:0]      daddr;
    logic [31:0]      dstore;
    logic             dwait;
    logic [31:0]      dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [1:0]       ramstate;
    logic [31:0]      ramload;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .MAX_DSTREAK (4),
        .BAD         (c_BAD)
    ) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramstate (ramstate),
        .ramload  (ramload)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        logic [31:0] v_data;
        logic [1:0]  v_iwait;
        int          v_g;

        nRST     = 1'b0;
        iREN     = 2'b00;
        iaddr[0] = c_IADDR0;
        iaddr[1] = c_IADDR1;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        ramstate = c_FREE;
        ramload  = 32'd0;

        // reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_iwait",    32'(iwait),   32'd3);
        chk("rst_dwait",    32'(dwait),   32'd1);
        chk("rst_ramREN",   32'(ramREN),  32'd0);
        chk("rst_ramWEN",   32'(ramWEN),  32'd0);
        chk("rst_ramaddr",  ramaddr,      32'd0);
        chk("rst_ramstore", ramstore,     32'd0);
        chk("rst_iload0",   iload[0],     c_BAD);
        chk("rst_iload1",   iload[1],     c_BAD);
        chk("rst_dload",    dload,        c_BAD);

        // data read with two-cycle RAM latency
        @(negedge CLK); nRST = 1'b1; dREN = 1'b1; daddr = 32'h100; ramstate = c_FREE; #1;
        chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
        chk("t1_idle_dwait",  32'(dwait),  32'd1);
        @(negedge CLK); ramstate = c_BUSY; #1;
        chk("t1_ramREN",  32'(ramREN), 32'd1);
        chk("t1_ramaddr", ramaddr,     32'h100);
        chk("t1_dwait_b", 32'(dwait),  32'd1);
        @(negedge CLK); ramstate = c_BUSY; #1;
        chk("t1_dwait_b2", 32'(dwait), 32'd1);
        @(negedge CLK); ramstate = c_ACCESS; ramload = 32'h12345678; #1;
        chk("t1_dwait_acc", 32'(dwait), 32'd0);
        chk("t1_dload",     dload,      32'h12345678);
        @(negedge CLK); dREN = 1'b0; ramstate = c_FREE; #1;
        chk("t1_post_dwait",  32'(dwait),  32'd1);
        chk("t1_post_dload",  dload,       c_BAD);
        chk("t1_post_ramREN", 32'(ramREN), 32'd0);

        // icache round-robin: core0, core1, core0
        @(negedge CLK); iREN = 2'b11; #1;
        chk("t2_idle_iwait", 32'(iwait), 32'd3);
        for (int k = 0; k < 3; k++) begin
            v_g     = k % 2;
            v_data  = 32'hA000_0000 + 32'(k);
            v_iwait = (v_g == 0) ? 2'b10 : 2'b01;
            @(negedge CLK); ramstate = c_ACCESS; ramload = v_data; #1;
            chk("t2_iwait",    32'(iwait), 32'(v_iwait));
            chk("t2_iload_g",  iload[v_g],     v_data);
            chk("t2_iload_ng", iload[1 - v_g], c_BAD);
            chk("t2_ramaddr",  ramaddr, (v_g == 0) ? c_IADDR0 : c_IADDR1);
            @(negedge CLK); ramstate = c_FREE;
            if (k == 2) iREN = 2'b00;
            #1;
            chk("t2_gap_iwait", 32'(iwait), 32'd3);
        end

        // data streak: four writes, then forced fetch for core1, then data resumes
        @(negedge CLK); dWEN = 1'b1; dstore = 32'hCAFEF00D; daddr = 32'h200; iREN = 2'b10;
        ramstate = c_FREE; #1;
        chk("t3_idle_ramWEN", 32'(ramWEN), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); ramstate = c_ACCESS; #1;
            chk("t3_wr_ramWEN",   32'(ramWEN), 32'd1);
            chk("t3_wr_ramREN",   32'(ramREN), 32'd0);
            chk("t3_wr_ramstore", ramstore,    32'hCAFEF00D);
            chk("t3_wr_dwait",    32'(dwait),  32'd0);
            @(negedge CLK); ramstate = c_FREE; #1;
            chk("t3_gap_ramWEN",  32'(ramWEN), 32'd0);
        end
        @(negedge CLK); ramstate = c_ACCESS; ramload = 32'h1111_0000; #1;
        chk("t3_fetch_iwait",  32'(iwait),  32'd1);
        chk("t3_fetch_ramREN", 32'(ramREN), 32'd1);
        chk("t3_fetch_ramWEN", 32'(ramWEN), 32'd0);
        chk("t3_fetch_iload1", iload[1],    32'h1111_0000);
        chk("t3_fetch_dwait",  32'(dwait),  32'd1);
        @(negedge CLK); ramstate = c_FREE; #1;
        @(negedge CLK); ramstate = c_ACCESS; #1;
        chk("t3_resume_ramWEN", 32'(ramWEN), 32'd1);
        @(negedge CLK); dWEN = 1'b0; iREN = 2'b00; ramstate = c_FREE; #1;

        // simultaneous read and write: write wins
        @(negedge CLK); dREN = 1'b1; dWEN = 1'b1; dstore = 32'h5A5A0F0F; #1;
        @(negedge CLK); ramstate = c_BUSY; #1;
        chk("t4_ramWEN",   32'(ramWEN), 32'd1);
        chk("t4_ramREN",   32'(ramREN), 32'd0);
        chk("t4_ramstore", ramstore,    32'h5A5A0F0F);
        chk("t4_busy_dwait", 32'(dwait), 32'd1);
        @(negedge CLK); ramstate = c_ACCESS; #1;
        chk("t4_dwait", 32'(dwait), 32'd0);
        @(negedge CLK); dREN = 1'b0; dWEN = 1'b0; ramstate = c_FREE; #1;

        // icache withdrawal while RAM busy
        @(negedge CLK); iREN = 2'b01; #1;
        @(negedge CLK); ramstate = c_BUSY; #1;
        chk("t5_ramREN",  32'(ramREN), 32'd1);
        chk("t5_ramaddr", ramaddr,     c_IADDR0);
        chk("t5_iwait",   32'(iwait),  32'd3);
        @(negedge CLK); iREN = 2'b00; #1;
        chk("t5_wd_ramREN", 32'(ramREN), 32'd0);
        chk("t5_wd_iwait",  32'(iwait),  32'd3);
        @(negedge CLK); iREN = 2'b11; ramstate = c_FREE; #1;
        @(negedge CLK); ramstate = c_ACCESS; ramload = 32'h2222_0000; #1;
        chk("t5_regrant_iwait", 32'(iwait), 32'd2);
        chk("t5_regrant_iload", iload[0],   32'h2222_0000);
        @(negedge CLK); iREN = 2'b00; ramstate = c_FREE; #1;

        // asynchronous reset during a data transfer
        @(negedge CLK); dWEN = 1'b1; dstore = 32'h0000_0077; #1;
        @(negedge CLK); ramstate = c_BUSY; #1;
        chk("t6_pre_ramWEN", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("t6_rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("t6_rst_ramREN", 32'(ramREN), 32'd0);
        chk("t6_rst_dwait",  32'(dwait),  32'd1);
        chk("t6_rst_dload",  dload,       c_BAD);
        @(negedge CLK); nRST = 1'b1; dWEN = 1'b0; iREN = 2'b11; ramstate = c_FREE; #1;
        chk("t6_idle_iwait", 32'(iwait), 32'd3);
        @(negedge CLK); ramstate = c_ACCESS; ramload = 32'h3333_0000; #1;
        chk("t6_rr_iwait", 32'(iwait), 32'd2);
        chk("t6_rr_iload", iload[0],   32'h3333_0000);
        @(negedge CLK); iREN = 2'b00; ramstate = c_FREE; #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
